traffic_phase_scheduler: RTL and testbench

Phase scheduler for a two-road intersection with a pedestrian crossing. It sequences main-road, cross-road and pedestrian-walk phases from vehicle-demand, pedestrian-button and emergency-preempt inputs, using minimum and maximum green times and fixed yellow, all-red and walk intervals. It drives the per-road light outputs and the walk signal directly. It replaces the fixed-cycle light FSM wherever demand-actuated operation is needed.

---
 rtl/traffic_phase_scheduler_pkg.sv | 33 +++
 rtl/traffic_phase_scheduler_if.sv | 30 +++
 rtl/traffic_phase_scheduler_timer.sv | 35 +++
 rtl/traffic_phase_scheduler.sv | 128 ++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared encodings for the demand-actuated intersection scheduler:
// phase codes, light codes and the Moore light decode.
package traffic_pkg;

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    ARC = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    ARM = 3'd5,
    PW  = 3'd6
  } phase_e;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  // Returns {main, cross}; anything not a road phase is all-red.
  function automatic logic [5:0] lights_of(input logic [2:0] p);
    logic [5:0] l;
    l = {RED, RED};
    case (p)
      3'd0:    l = {GREEN, RED};
      3'd1:    l = {YELLOW, RED};
      3'd3:    l = {RED, GREEN};
      3'd4:    l = {RED, YELLOW};
      default: l = {RED, RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Request inputs and light/status outputs of the scheduler.
// master drives requests; slave is the scheduler side.
interface traffic_phase_scheduler_if;

  logic       tick;
  logic       main_req;
  logic       cross_req;
  logic       ped_req;
  logic       emerg;
  logic [2:0] light_main;
  logic [2:0] light_cross;
  logic       walk;
  logic [2:0] phase;
  logic       ped_pending;

  modport master (
    output tick, main_req, cross_req,
    output ped_req, emerg,
    input  light_main, light_cross,
    input  walk, phase, ped_pending
  );

  modport slave (
    input  tick, main_req, cross_req,
    input  ped_req, emerg,
    output light_main, light_cross,
    output walk, phase, ped_pending
  );

endinterface

// File: rtl/traffic_phase_scheduler_timer.sv
// Elapsed-ticks counter for the current phase: clears on phase
// change, advances on tick, saturates at all-ones.
module traffic_phase_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_i,
  input  logic          tick_i,
  output logic [TW-1:0] elapsed_o
);

  logic [TW-1:0] elapsed_q;
  logic [TW-1:0] elapsed_d;

  always_comb begin
    elapsed_d = elapsed_q;
    if (clr_i) begin
      elapsed_d = '0;
    end else if (tick_i && (elapsed_q != '1)) begin
      elapsed_d = elapsed_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      elapsed_q <= '0;
    end else begin
      elapsed_q <= elapsed_d;
    end
  end

  assign elapsed_o = elapsed_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated phase scheduler: main-road rest, cross-road
// service, pedestrian walk and emergency preempt toward main.
module traffic_phase_scheduler #(
  parameter int GREEN_MIN   = 4,
  parameter int GREEN_MAX   = 10,
  parameter int YELLOW_TIME = 2,
  parameter int ALLRED_TIME = 1,
  parameter int WALK_TIME   = 5,
  parameter int TW          = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  traffic_phase_scheduler_if.slave  bus
);

  import traffic_pkg::*;

  localparam logic [TW-1:0] GMIN_M1 = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] GMAX_M1 = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] YEL_M1  = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] AR_M1   = TW'(ALLRED_TIME - 1);
  localparam logic [TW-1:0] WALK_M1 = TW'(WALK_TIME - 1);

  phase_e        state_q;
  phase_e        state_d;
  logic          ped_q;
  logic          ped_d;
  logic          clr;
  logic [TW-1:0] elapsed;
  logic          done_gmin;
  logic          at_gmax;
  logic          done_yel;
  logic          done_ar;
  logic          done_walk;
  logic          demand;
  logic [5:0]    lights;
  logic          unused_main;

  // Main is the rest phase, so its demand never changes sequencing.
  assign unused_main = bus.main_req;

  traffic_phase_timer #(
    .TW (TW)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (clr),
    .tick_i    (bus.tick),
    .elapsed_o (elapsed)
  );

  assign done_gmin = bus.tick && (elapsed >= GMIN_M1);
  assign at_gmax   = elapsed >= GMAX_M1;
  assign done_yel  = bus.tick && (elapsed >= YEL_M1);
  assign done_ar   = bus.tick && (elapsed >= AR_M1);
  assign done_walk = bus.tick && (elapsed >= WALK_M1);
  assign demand    = bus.cross_req || ped_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MG: begin
        if (done_gmin && demand && !bus.emerg) state_d = MY;
      end
      MY: begin
        if (done_yel) state_d = ARC;
      end
      ARC: begin
        if (done_ar) begin
          if (bus.emerg)  state_d = ARM;
          else if (ped_q) state_d = PW;
          else            state_d = CG;
        end
      end
      PW: begin
        if (bus.emerg) begin
          state_d = ARM;
        end else if (done_walk) begin
          state_d = bus.cross_req ? CG : ARM;
        end
      end
      CG: begin
        if (bus.emerg) begin
          state_d = CY;
        end else if (done_gmin && (!bus.cross_req || at_gmax)) begin
          state_d = CY;
        end
      end
      CY: begin
        if (done_yel) state_d = ARM;
      end
      ARM: begin
        if (done_ar) state_d = MG;
      end
      default: state_d = ARM;
    endcase
  end

  assign clr = (state_d != state_q);

  // A press on the very edge that enters walk must not be lost.
  always_comb begin
    ped_d = ped_q;
    if (bus.ped_req) begin
      ped_d = 1'b1;
    end else if (state_d == PW && state_q != PW) begin
      ped_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MG;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ped_q   <= ped_d;
    end
  end

  assign lights          = lights_of(state_q);
  assign bus.light_main  = lights[5:3];
  assign bus.light_cross = lights[2:0];
  assign bus.walk        = (state_q == PW);
  assign bus.phase       = state_q;
  assign bus.ped_pending = ped_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed scenarios with a scoreboard queue; a separate monitor
// pops and compares after each clock edge and after async resets.
module tb_traffic_phase_scheduler;

  import traffic_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  traffic_phase_scheduler_if ifc ();

  traffic_phase_scheduler dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  typedef struct {
    phase_e ph;
    logic   pp;
    string  tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  event async_ev;

  logic t_i, m_i, c_i, p_i, e_i;

  function automatic logic [2:0] exp_main(input phase_e p);
    if (p == MG) return 3'b001;
    if (p == MY) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] exp_cross(input phase_e p);
    if (p == CG) return 3'b001;
    if (p == CY) return 3'b010;
    return 3'b100;
  endfunction

  task automatic drive();
    ifc.tick      = t_i;
    ifc.main_req  = m_i;
    ifc.cross_req = c_i;
    ifc.ped_req   = p_i;
    ifc.emerg     = e_i;
  endtask

  task automatic step(input phase_e ph, input logic pp,
                      input string tag);
    @(negedge clk);
    reset_n = 1'b1;
    drive();
    sb.push_back('{ph, pp, tag});
  endtask

  task automatic run(input int n, input phase_e ph,
                     input logic pp, input string tag);
    repeat (n) step(ph, pp, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    t_i = 1'b1; m_i = 1'b0; c_i = 1'b0;
    p_i = 1'b0; e_i = 1'b0;
    drive();
    sb.push_back('{MG, 1'b0, {tag, "_async"}});
    #1 -> async_ev;
    sb.push_back('{MG, 1'b0, tag});
  endtask

  initial begin : monitor
    exp_t e;
    logic [2:0] lm, lc;
    logic w;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        lm = exp_main(e.ph);
        lc = exp_cross(e.ph);
        w  = (e.ph == PW);
        n_vec++;
        if (ifc.phase !== e.ph || ifc.light_main !== lm ||
            ifc.light_cross !== lc || ifc.walk !== w ||
            ifc.ped_pending !== e.pp) begin
          n_bad++;
          $display("FAIL %s @%0t: got ph=%0d lm=%b lc=%b walk=%b ped=%b, want ph=%0d lm=%b lc=%b walk=%b ped=%b",
                   e.tag, $time, ifc.phase, ifc.light_main,
                   ifc.light_cross, ifc.walk, ifc.ped_pending,
                   e.ph, lm, lc, w, e.pp);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset_n = 1'b0;
    t_i = 1'b1; m_i = 1'b0; c_i = 1'b0;
    p_i = 1'b0; e_i = 1'b0;
    drive();

    do_reset("rst");
    run(50, MG, 1'b0, "rest");

    do_reset("rst_x");
    c_i = 1'b1;
    run(3, MG, 1'b0, "x_mg");
    run(2, MY, 1'b0, "x_my");
    run(1, ARC, 1'b0, "x_arc");
    run(10, CG, 1'b0, "x_cg_max");
    run(2, CY, 1'b0, "x_cy");
    run(1, ARM, 1'b0, "x_arm");
    run(1, MG, 1'b0, "x_back");

    do_reset("rst_s");
    c_i = 1'b1;
    run(3, MG, 1'b0, "s_mg");
    run(2, MY, 1'b0, "s_my");
    run(1, ARC, 1'b0, "s_arc");
    run(2, CG, 1'b0, "s_cg");
    c_i = 1'b0;
    run(2, CG, 1'b0, "s_cg_min");
    run(2, CY, 1'b0, "s_cy");
    run(1, ARM, 1'b0, "s_arm");
    run(3, MG, 1'b0, "s_rest");

    do_reset("rst_p");
    p_i = 1'b1;
    step(MG, 1'b1, "p_latch");
    p_i = 1'b0;
    run(2, MG, 1'b1, "p_mg");
    run(2, MY, 1'b1, "p_my");
    run(1, ARC, 1'b1, "p_arc");
    run(5, PW, 1'b0, "p_walk");
    run(1, ARM, 1'b0, "p_arm");
    run(2, MG, 1'b0, "p_mg2");

    do_reset("rst_pw");
    p_i = 1'b1;
    step(MG, 1'b1, "pw_latch");
    p_i = 1'b0;
    run(2, MG, 1'b1, "pw_mg");
    run(2, MY, 1'b1, "pw_my");
    run(1, ARC, 1'b1, "pw_arc");
    p_i = 1'b1;
    step(PW, 1'b1, "pw_setwins");
    p_i = 1'b0;
    run(4, PW, 1'b1, "pw_walk");
    run(1, ARM, 1'b1, "pw_arm");
    run(4, MG, 1'b1, "pw_mg_min");
    run(1, MY, 1'b1, "pw_reserve");

    do_reset("rst_e");
    c_i = 1'b1;
    run(3, MG, 1'b0, "e_mg");
    run(2, MY, 1'b0, "e_my");
    run(1, ARC, 1'b0, "e_arc");
    run(1, CG, 1'b0, "e_cg");
    e_i = 1'b1;
    step(CY, 1'b0, "e_preempt");
    run(1, CY, 1'b0, "e_cy");
    run(1, ARM, 1'b0, "e_arm");
    run(8, MG, 1'b0, "e_hold");
    e_i = 1'b0;
    step(MY, 1'b0, "e_late_demand");

    do_reset("rst_ep");
    p_i = 1'b1;
    step(MG, 1'b1, "ep_latch");
    p_i = 1'b0;
    run(2, MG, 1'b1, "ep_mg");
    run(2, MY, 1'b1, "ep_my");
    run(1, ARC, 1'b1, "ep_arc");
    run(1, PW, 1'b0, "ep_pw");
    e_i = 1'b1;
    step(ARM, 1'b0, "ep_preempt");
    run(3, MG, 1'b0, "ep_hold");
    e_i = 1'b0;

    do_reset("rst_t");
    c_i = 1'b1;
    step(MG, 1'b0, "t_mg");
    t_i = 1'b0;
    run(10, MG, 1'b0, "t_freeze_mg");
    t_i = 1'b1;
    run(2, MG, 1'b0, "t_mg2");
    step(MY, 1'b0, "t_my");
    t_i = 1'b0;
    run(3, MY, 1'b0, "t_freeze_my");
    t_i = 1'b1;
    step(MY, 1'b0, "t_my2");
    step(ARC, 1'b0, "t_arc");

    do_reset("rst_c");
    c_i = 1'b1;
    run(3, MG, 1'b0, "c_mg");
    run(2, MY, 1'b0, "c_my");
    run(1, ARC, 1'b0, "c_arc");
    c_i = 1'b0;
    run(4, CG, 1'b0, "c_cg");
    run(1, CY, 1'b0, "c_cy");
    do_reset("rst_mid_cy");
    step(MG, 1'b0, "c_after");

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
